// File: rtl/uart_rx_param_if.sv
// Serial-in / word-out bundle for the parametrised UART receiver.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_Rx_Serial;
  logic                 o_Rx_DV;
  logic [DATA_BITS-1:0] o_Rx_Byte;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Break;

  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break
  );

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 5-9 data bits, none/odd/even parity, 1-2 stop bits,
// 3-sample majority vote at mid-bit, parity/framing/break status per word.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  uart_rx_param_if.slave rx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF      = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_HIGH
  } state_t;

  logic rx_meta, rx_sync, rx_h1, rx_h2;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] bit_idx, bit_idx_n;
  logic stop_idx, stop_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic par_bit, par_bit_n;
  logic perr_acc, perr_acc_n;
  logic ferr_acc, ferr_acc_n;
  logic dv_r, dv_n;
  logic [DATA_BITS-1:0] byte_r, byte_n;
  logic perr_r, perr_n, ferr_r, ferr_n, brk_r, brk_n;
  logic sample, tick, ferr_final;

  assign sample     = (rx_sync & rx_h1) | (rx_sync & rx_h2) | (rx_h1 & rx_h2);
  assign tick       = (cnt == LAST_CNT);
  assign ferr_final = ferr_acc | ~sample;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_h1    <= 1'b1;
      rx_h2    <= 1'b1;
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
      dv_r     <= 1'b0;
      byte_r   <= '0;
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
      brk_r    <= 1'b0;
    end else begin
      rx_meta  <= rx.i_Rx_Serial;
      rx_sync  <= rx_meta;
      rx_h1    <= rx_sync;
      rx_h2    <= rx_h1;
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      shreg    <= shreg_n;
      par_bit  <= par_bit_n;
      perr_acc <= perr_acc_n;
      ferr_acc <= ferr_acc_n;
      dv_r     <= dv_n;
      byte_r   <= byte_n;
      perr_r   <= perr_n;
      ferr_r   <= ferr_n;
      brk_r    <= brk_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    shreg_n    = shreg;
    par_bit_n  = par_bit;
    perr_acc_n = perr_acc;
    ferr_acc_n = ferr_acc;
    dv_n       = 1'b0;
    byte_n     = byte_r;
    perr_n     = perr_r;
    ferr_n     = ferr_r;
    brk_n      = brk_r;
    unique case (state)
      IDLE: begin
        cnt_n      = '0;
        bit_idx_n  = '0;
        stop_idx_n = 1'b0;
        shreg_n    = '0;
        par_bit_n  = 1'b0;
        perr_acc_n = 1'b0;
        ferr_acc_n = 1'b0;
        if (!rx_sync) state_n = START;
      end
      START: begin
        // Start-bit check uses the raw synchronised line so a short glitch aborts.
        if (cnt == HALF) begin
          cnt_n   = '0;
          state_n = rx_sync ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          cnt_n     = '0;
          // LSB-first: each bit enters at the top, so after DATA_BITS shifts bit 0 is at [0].
          shreg_n   = {sample, shreg[DATA_BITS-1:1]};
          bit_idx_n = bit_idx + IW'(1);
          if (bit_idx == LAST_BIT) state_n = (PARITY_MODE != 0) ? PARITY : STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      PARITY: begin
        if (tick) begin
          cnt_n      = '0;
          par_bit_n  = sample;
          perr_acc_n = ((^shreg) ^ sample) != (PARITY_MODE == 1);
          state_n    = STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          cnt_n      = '0;
          ferr_acc_n = ferr_final;
          stop_idx_n = ~stop_idx;
          if (stop_idx == LAST_STOP) begin
            dv_n    = 1'b1;
            byte_n  = shreg;
            perr_n  = perr_acc;
            ferr_n  = ferr_final;
            brk_n   = ferr_final & ~(|shreg) & ~par_bit;
            state_n = CLEANUP;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      CLEANUP: begin
        cnt_n   = '0;
        state_n = ferr_r ? WAIT_HIGH : IDLE;
      end
      WAIT_HIGH: begin
        if (rx_sync) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx.o_Rx_DV      = dv_r;
  assign rx.o_Rx_Byte    = byte_r;
  assign rx.o_Parity_Err = perr_r;
  assign rx.o_Frame_Err  = ferr_r;
  assign rx.o_Break      = brk_r;
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three configurations (8N1, 7E2, 8O1) at 16 clocks/bit.
module tb_uart_rx_param;
  localparam int CPB = 16;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    int         gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  longint cyc = 0;
  longint last_a = 0, last_b = 0, last_c = 0;
  int tests = 0;
  int fails = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(7)) if_b ();
  uart_rx_param_if #(.DATA_BITS(8)) if_c ();

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .rx(if_a.slave));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
    .i_Clock(clk), .i_Reset(rst), .rx(if_b.slave));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut_c (
    .i_Clock(clk), .i_Reset(rst), .rx(if_c.slave));

  task automatic check_dv(input string nm, input bit none, input exp_t e, input logic [8:0] d,
                          input logic pe, input logic fe, input logic bk, input longint gap);
    tests++;
    if (none) begin
      fails++;
      $display("FAIL %s unexpected DV: got byte=%h pe=%b fe=%b brk=%b, required no DV", nm, d, pe, fe, bk);
    end else if (d !== e.data || pe !== e.perr || fe !== e.ferr || bk !== e.brk ||
                 (e.gap != 0 && gap != longint'(e.gap))) begin
      fails++;
      $display("FAIL %s word: got byte=%h pe=%b fe=%b brk=%b gap=%0d, required byte=%h pe=%b fe=%b brk=%b gap=%0d",
               nm, d, pe, fe, bk, gap, e.data, e.perr, e.ferr, e.brk, e.gap);
    end
  endtask

  task automatic check_zero(input string nm, input logic dv, input logic [8:0] d,
                            input logic pe, input logic fe, input logic bk);
    tests++;
    if (dv !== 1'b0 || d !== 9'h000 || pe !== 1'b0 || fe !== 1'b0 || bk !== 1'b0) begin
      fails++;
      $display("FAIL %s: got dv=%b byte=%h pe=%b fe=%b brk=%b, required all 0", nm, dv, d, pe, fe, bk);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    bit none;
    if (if_a.o_Rx_DV === 1'b1) begin
      none = (q_a.size() == 0);
      e = '{9'h000, 1'b0, 1'b0, 1'b0, 0};
      if (!none) e = q_a.pop_front();
      check_dv("8N1", none, e, {1'b0, if_a.o_Rx_Byte}, if_a.o_Parity_Err, if_a.o_Frame_Err,
               if_a.o_Break, cyc - last_a);
      last_a = cyc;
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    bit none;
    if (if_b.o_Rx_DV === 1'b1) begin
      none = (q_b.size() == 0);
      e = '{9'h000, 1'b0, 1'b0, 1'b0, 0};
      if (!none) e = q_b.pop_front();
      check_dv("7E2", none, e, {2'b00, if_b.o_Rx_Byte}, if_b.o_Parity_Err, if_b.o_Frame_Err,
               if_b.o_Break, cyc - last_b);
      last_b = cyc;
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    bit none;
    if (if_c.o_Rx_DV === 1'b1) begin
      none = (q_c.size() == 0);
      e = '{9'h000, 1'b0, 1'b0, 1'b0, 0};
      if (!none) e = q_c.pop_front();
      check_dv("8O1", none, e, {1'b0, if_c.o_Rx_Byte}, if_c.o_Parity_Err, if_c.o_Frame_Err,
               if_c.o_Break, cyc - last_c);
      last_c = cyc;
    end
  end

  task automatic set_line(input int w, input logic v);
    case (w)
      0: if_a.i_Rx_Serial = v;
      1: if_b.i_Rx_Serial = v;
      default: if_c.i_Rx_Serial = v;
    endcase
  endtask

  // Drive the line just after an edge and hold it for n clocks.
  task automatic hold(input int w, input logic v, input int n);
    set_line(w, v);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int w, input logic [8:0] d, input int nb, input int pm,
                      input bit flip, input int ns);
    logic p;
    p = 1'b0;
    hold(w, 1'b0, CPB);
    for (int i = 0; i < nb; i++) begin
      hold(w, d[i], CPB);
      p = p ^ d[i];
    end
    if (pm != 0) begin
      if (pm == 1) p = ~p;
      if (flip) p = ~p;
      hold(w, p, CPB);
    end
    for (int i = 0; i < ns; i++) hold(w, 1'b1, CPB);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    if_a.i_Rx_Serial = 1'b1;
    if_b.i_Rx_Serial = 1'b1;
    if_c.i_Rx_Serial = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("reset_8N1", if_a.o_Rx_DV, {1'b0, if_a.o_Rx_Byte}, if_a.o_Parity_Err, if_a.o_Frame_Err, if_a.o_Break);
    check_zero("reset_7E2", if_b.o_Rx_DV, {2'b00, if_b.o_Rx_Byte}, if_b.o_Parity_Err, if_b.o_Frame_Err, if_b.o_Break);
    check_zero("reset_8O1", if_c.o_Rx_DV, {1'b0, if_c.o_Rx_Byte}, if_c.o_Parity_Err, if_c.o_Frame_Err, if_c.o_Break);
    hold(0, 1'b1, 20);

    // 8N1 back-to-back: 10 bits x 16 clocks between strobes
    q_a.push_back('{9'h0A5, 1'b0, 1'b0, 1'b0, 0});
    q_a.push_back('{9'h03C, 1'b0, 1'b0, 1'b0, 160});
    send(0, 9'h0A5, 8, 0, 1'b0, 1);
    send(0, 9'h03C, 8, 0, 1'b0, 1);
    hold(0, 1'b1, 32);

    // 0x00 with a one-clock high spike at the middle of data bit 3
    q_a.push_back('{9'h000, 1'b0, 1'b0, 1'b0, 0});
    hold(0, 1'b0, CPB);
    hold(0, 1'b0, 3 * CPB);
    hold(0, 1'b0, 8);
    hold(0, 1'b1, 1);
    hold(0, 1'b0, 7);
    hold(0, 1'b0, 4 * CPB);
    hold(0, 1'b1, CPB);
    hold(0, 1'b1, 32);

    // Break: line low for 30 bit times, then a clean frame
    q_a.push_back('{9'h000, 1'b0, 1'b1, 1'b1, 0});
    hold(0, 1'b0, 30 * CPB);
    hold(0, 1'b1, 48);
    q_a.push_back('{9'h07E, 1'b0, 1'b0, 1'b0, 0});
    send(0, 9'h07E, 8, 0, 1'b0, 1);
    hold(0, 1'b1, 32);

    // 7E2: good parity, then flipped parity bit
    q_b.push_back('{9'h055, 1'b0, 1'b0, 1'b0, 0});
    send(1, 9'h055, 7, 2, 1'b0, 2);
    hold(1, 1'b1, 32);
    q_b.push_back('{9'h055, 1'b1, 1'b0, 1'b0, 0});
    send(1, 9'h055, 7, 2, 1'b1, 2);
    hold(1, 1'b1, 32);

    // 8O1: one-clock low glitch is rejected, then 0x81 with odd parity bit 1
    hold(2, 1'b0, 1);
    hold(2, 1'b1, 6);
    hold(2, 1'b1, 40);
    q_c.push_back('{9'h081, 1'b0, 1'b0, 1'b0, 0});
    send(2, 9'h081, 8, 1, 1'b0, 1);
    hold(2, 1'b1, 32);

    // Reset during data bit 4 of 0xF3 (bits 4..7 and stop are high, so no false start afterwards)
    hold(0, 1'b0, CPB);
    hold(0, 1'b1, CPB);
    hold(0, 1'b1, CPB);
    hold(0, 1'b0, CPB);
    hold(0, 1'b0, CPB);
    hold(0, 1'b1, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("midframe_reset_8N1", if_a.o_Rx_DV, {1'b0, if_a.o_Rx_Byte}, if_a.o_Parity_Err,
               if_a.o_Frame_Err, if_a.o_Break);
    hold(0, 1'b1, 11);
    hold(0, 1'b1, 4 * CPB);
    hold(0, 1'b1, 16);
    q_a.push_back('{9'h0F0, 1'b0, 1'b0, 1'b0, 0});
    send(0, 9'h0F0, 8, 0, 1'b0, 1);
    hold(0, 1'b1, 64);

    tests++;
    if (q_a.size() != 0) begin
      fails++;
      $display("FAIL 8N1 missing DV: got %0d words outstanding, required 0", q_a.size());
    end
    tests++;
    if (q_b.size() != 0) begin
      fails++;
      $display("FAIL 7E2 missing DV: got %0d words outstanding, required 0", q_b.size());
    end
    tests++;
    if (q_c.size() != 0) begin
      fails++;
      $display("FAIL 8O1 missing DV: got %0d words outstanding, required 0", q_c.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
